// File: rtl/alu16_pkg.sv
// alu16_pkg
// Shared definitions for the ALU16 sharing controller: ALU16 op codes,
// op classification helpers and the controller state encoding.
// No ports (package).

package alu16_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [OP_W-1:0] ALU_MUL   = 4'd2;
   localparam logic [OP_W-1:0] ALU_DIV   = 4'd3;
   localparam logic [OP_W-1:0] ALU_SLL   = 4'd4;
   localparam logic [OP_W-1:0] ALU_SRL   = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRA   = 4'd6;
   localparam logic [OP_W-1:0] ALU_XOR   = 4'd7;
   localparam logic [OP_W-1:0] ALU_OR    = 4'd8;
   localparam logic [OP_W-1:0] ALU_AND   = 4'd9;
   localparam logic [OP_W-1:0] ALU_NOT   = 4'd10;
   localparam logic [OP_W-1:0] ALU_BOOTH = 4'd11;
   localparam logic [OP_W-1:0] ALU_NRDIV = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // multi-cycle datapaths inside ALU16 need the long hold time
   function automatic logic is_slow_op(input logic [OP_W-1:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV) ||
             (op == ALU_BOOTH) || (op == ALU_NRDIV);
   endfunction

   function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
      return op > ALU_NRDIV;
   endfunction

   // ops that trap on a zero divisor
   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == ALU_DIV) || (op == ALU_NRDIV);
   endfunction

endpackage

// File: rtl/alu16_arbiter_ctrl_rr_arb2.sv
// rr_arb2
// Two-way round-robin grant. A lone valid requester wins; on a tie the
// requester that was not granted last wins.
// Ports:
//   valid[1:0]  in   request present per requester
//   last_grant  in   requester granted most recently
//   grant       out  index of the winning requester (meaningful when any valid)

module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant
);

   always_comb begin
      grant = 1'b0;
      case (valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu16_arbiter_ctrl.sv
// alu16_arbiter_ctrl
// Shares one ALU16 between two requesters. Accepted operands/op are held
// on the ALU inputs for an op-dependent latency, then the ALU result and
// flags are captured into a response register held until consumed.
// Illegal ops and divide-by-zero skip the ALU and respond with resp_err.
// Ports:
//   clk, reset                      clock, async active-high reset
//   req{0,1}_valid/_ready           request handshake (ready is combinational)
//   req{0,1}_a/_b/_op               request payload
//   resp_valid/resp_ready           response handshake
//   resp_id/out/overflow/zero/err   response payload
//   alu_a/alu_b/alu_op              ALU16 inputs (registered)
//   alu_out/alu_overflow/alu_zero   ALU16 outputs
//   busy                            controller not idle
//
// state | meaning
// IDLE  | waiting for a request, arbitration active
// EXEC  | ALU inputs held, cnt counting down to capture
// RESP  | response valid, waiting for resp_ready

module alu16_arbiter_ctrl
   import alu16_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int LAT_FAST = 1,
   parameter int LAT_SLOW = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_out,
   output logic             resp_overflow,
   output logic             resp_zero,
   output logic             resp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   output logic             busy
);

   localparam int LAT_MAX = (LAT_FAST > LAT_SLOW) ? LAT_FAST : LAT_SLOW;
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(LAT_FAST - 1);
   localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(LAT_SLOW - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [3:0]       sel_op;
   logic             sel_bad;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // reset is folded in so no ready can leak out while the block is held
   assign req0_ready = !reset && (state == IDLE) && req0_valid && !grant;
   assign req1_ready = !reset && (state == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;

   assign sel_a   = grant ? req1_a  : req0_a;
   assign sel_b   = grant ? req1_b  : req0_b;
   assign sel_op  = grant ? req1_op : req0_op;
   assign sel_bad = is_illegal_op(sel_op) || (is_div_op(sel_op) && (sel_b == '0));

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         last_grant    <= 1'b1;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= '0;
         resp_valid    <= 1'b0;
         resp_id       <= 1'b0;
         resp_out      <= '0;
         resp_overflow <= 1'b0;
         resp_zero     <= 1'b0;
         resp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a      <= sel_a;
                  alu_b      <= sel_b;
                  alu_op     <= sel_op;
                  resp_id    <= grant;
                  last_grant <= grant;
                  if (sel_bad) begin
                     state         <= RESP;
                     resp_valid    <= 1'b1;
                     resp_err      <= 1'b1;
                     resp_out      <= '0;
                     resp_overflow <= 1'b0;
                     resp_zero     <= 1'b0;
                  end else begin
                     state <= EXEC;
                     cnt   <= is_slow_op(sel_op) ? CNT_SLOW : CNT_FAST;
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  state         <= RESP;
                  resp_valid    <= 1'b1;
                  resp_err      <= 1'b0;
                  resp_out      <= alu_out;
                  resp_overflow <= alu_overflow;
                  resp_zero     <= alu_zero;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu16_arbiter_ctrl.sv
module tb_alu16_arbiter_ctrl;

   logic        clk, reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        resp_valid, resp_ready, resp_id, resp_overflow, resp_zero, resp_err;
   logic [15:0] resp_out;
   logic signed [15:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_out;
   logic        alu_overflow, alu_zero, busy;
   logic signed [31:0] prod;

   int tests = 0;
   int fails = 0;

   alu16_arbiter_ctrl #(.WIDTH(16), .LAT_FAST(1), .LAT_SLOW(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out),
      .resp_overflow(resp_overflow), .resp_zero(resp_zero), .resp_err(resp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .busy(busy)
   );

   // small ALU16 stand-in covering the ops the bench issues
   always_comb begin
      alu_out      = 16'h0000;
      alu_overflow = 1'b0;
      prod         = 32'sd0;
      case (alu_op)
         4'd0: begin
            alu_out = alu_a + alu_b;
            alu_overflow = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
         end
         4'd1: begin
            alu_out = alu_a - alu_b;
            alu_overflow = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
         end
         4'd2: begin
            prod = alu_a * alu_b;
            alu_out = prod[15:0];
            alu_overflow = (prod > 32'sd32767) || (prod < -32'sd32768);
         end
         4'd9: alu_out = alu_a & alu_b;
         default: alu_out = 16'h0000;
      endcase
      alu_zero = (alu_out == 16'h0000);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #2;
      tests++;
      if ({busy, resp_valid, resp_out, resp_id, resp_err, alu_a, alu_op, req0_ready, req1_ready} !== 40'd0) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b rv=%b out=%h id=%b err=%b alu_a=%h op=%h r0=%b r1=%b expected all 0",
                  busy, resp_valid, resp_out, resp_id, resp_err, alu_a, alu_op, req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_fast;
      @(negedge clk);
      req0_a = 16'hFDEF; req0_b = 16'd10; req0_op = 4'd0; req0_valid = 1'b1; #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++; $display("FAIL fast_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clk); @(negedge clk); req0_valid = 1'b0; #1;
      tests++;
      if ({busy, resp_valid, alu_a, alu_b, alu_op} !== {1'b1, 1'b0, 16'hFDEF, 16'd10, 4'd0}) begin
         fails++; $display("FAIL fast_exec: busy=%b rv=%b a=%h b=%h op=%h expected 1 0 fdef 000a 0",
                           busy, resp_valid, alu_a, alu_b, alu_op);
      end
      @(negedge clk); #1;
      tests++;
      if ({resp_valid, resp_out, resp_id, resp_err, resp_zero, resp_overflow} !== {1'b1, 16'hFDF9, 4'b0000}) begin
         fails++; $display("FAIL fast_resp: rv=%b out=%h id=%b err=%b z=%b ov=%b expected 1 fdf9 0 0 0 0",
                           resp_valid, resp_out, resp_id, resp_err, resp_zero, resp_overflow);
      end
      // consume while req1 arrives: it must wait for the next IDLE cycle
      resp_ready = 1'b1;
      req1_a = 16'd5; req1_b = 16'd5; req1_op = 4'd1; req1_valid = 1'b1; #1;
      tests++;
      if (req1_ready !== 1'b0) begin
         fails++; $display("FAIL resp_cycle_no_accept: req1_ready=%b expected 0", req1_ready);
      end
      @(negedge clk); resp_ready = 1'b0; #1;
      tests++;
      if ({busy, resp_valid, req1_ready} !== 3'b001) begin
         fails++; $display("FAIL b2b_idle: busy=%b rv=%b r1=%b expected 0 0 1", busy, resp_valid, req1_ready);
      end
      @(posedge clk); @(negedge clk); req1_valid = 1'b0;
      @(negedge clk); #1;
      tests++;
      if ({resp_valid, resp_out, resp_id, resp_zero, resp_err} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL b2b_resp: rv=%b out=%h id=%b z=%b err=%b expected 1 0000 1 1 0",
                           resp_valid, resp_out, resp_id, resp_zero, resp_err);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
   endtask

   task automatic test_slow_backpressure;
      @(negedge clk);
      req1_a = 16'd30; req1_b = 16'hFFD7; req1_op = 4'd2; req1_valid = 1'b1; #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         fails++; $display("FAIL slow_ready: got %b expected 01", {req0_ready, req1_ready});
      end
      @(posedge clk); @(negedge clk); req1_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         tests++;
         if ({busy, resp_valid, alu_a, alu_b, alu_op} !== {1'b1, 1'b0, 16'd30, 16'hFFD7, 4'd2}) begin
            fails++; $display("FAIL slow_hold[%0d]: busy=%b rv=%b a=%h b=%h op=%h expected 1 0 001e ffd7 2",
                              i, busy, resp_valid, alu_a, alu_b, alu_op);
         end
         @(negedge clk);
      end
      #1;
      tests++;
      if ({resp_valid, resp_out, resp_id, resp_err, resp_overflow} !== {1'b1, 16'hFB32, 1'b1, 2'b00}) begin
         fails++; $display("FAIL slow_resp: rv=%b out=%h id=%b err=%b ov=%b expected 1 fb32 1 0 0",
                           resp_valid, resp_out, resp_id, resp_err, resp_overflow);
      end
      // divide-by-zero request waits behind a stalled response
      req0_a = 16'd16900; req0_b = 16'd0; req0_op = 4'd3; req0_valid = 1'b1;
      repeat (5) begin
         @(negedge clk); #1;
         tests++;
         if ({resp_valid, resp_out, resp_id, req0_ready, busy} !== {1'b1, 16'hFB32, 1'b1, 1'b0, 1'b1}) begin
            fails++; $display("FAIL backpressure: rv=%b out=%h id=%b r0=%b busy=%b expected 1 fb32 1 0 1",
                              resp_valid, resp_out, resp_id, req0_ready, busy);
         end
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0; #1;
      tests++;
      if ({busy, resp_valid, req0_ready} !== 3'b001) begin
         fails++; $display("FAIL release_idle: busy=%b rv=%b r0=%b expected 0 0 1", busy, resp_valid, req0_ready);
      end
      @(posedge clk); @(negedge clk); req0_valid = 1'b0; #1;
      tests++;
      if ({resp_valid, resp_err, resp_out, resp_id, busy} !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b1}) begin
         fails++; $display("FAIL div0_err: rv=%b err=%b out=%h id=%b busy=%b expected 1 1 0000 0 1",
                           resp_valid, resp_err, resp_out, resp_id, busy);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
      req1_a = 16'd1234; req1_b = 16'd7; req1_op = 4'hD; req1_valid = 1'b1; #1;
      tests++;
      if (req1_ready !== 1'b1) begin
         fails++; $display("FAIL illegal_ready: got %b expected 1", req1_ready);
      end
      @(posedge clk); @(negedge clk); req1_valid = 1'b0; #1;
      tests++;
      if ({resp_valid, resp_err, resp_out, resp_id, resp_zero} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}) begin
         fails++; $display("FAIL illegal_err: rv=%b err=%b out=%h id=%b z=%b expected 1 1 0000 1 0",
                           resp_valid, resp_err, resp_out, resp_id, resp_zero);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
   endtask

   task automatic test_tie;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      req0_a = 16'd3; req0_b = 16'd2; req0_op = 4'd9;
      req1_a = 16'd3; req1_b = 16'd2; req1_op = 4'd9;
      req0_valid = 1'b1; req1_valid = 1'b1; #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++; $display("FAIL tie_first: got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clk); @(negedge clk); req0_valid = 1'b0; #1;
      tests++;
      if ({busy, req1_ready} !== 2'b10) begin
         fails++; $display("FAIL tie_exec: busy=%b r1=%b expected 1 0", busy, req1_ready);
      end
      @(negedge clk); #1;
      tests++;
      if ({resp_valid, resp_out, resp_id, busy} !== {1'b1, 16'h0002, 1'b0, 1'b1}) begin
         fails++; $display("FAIL tie_resp0: rv=%b out=%h id=%b busy=%b expected 1 0002 0 1",
                           resp_valid, resp_out, resp_id, busy);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0; #1;
      tests++;
      if ({busy, req0_ready, req1_ready} !== 3'b001) begin
         fails++; $display("FAIL tie_second: busy=%b r0=%b r1=%b expected 0 0 1", busy, req0_ready, req1_ready);
      end
      @(posedge clk); @(negedge clk); req1_valid = 1'b0;
      @(negedge clk); #1;
      tests++;
      if ({resp_valid, resp_out, resp_id, busy} !== {1'b1, 16'h0002, 1'b1, 1'b1}) begin
         fails++; $display("FAIL tie_resp1: rv=%b out=%h id=%b busy=%b expected 1 0002 1 1",
                           resp_valid, resp_out, resp_id, busy);
      end
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0; #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++; $display("FAIL tie_alternate: got %b expected 10", {req0_ready, req1_ready});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_exec;
      req1_a = 16'd30; req1_b = 16'hFFD7; req1_op = 4'd2; req1_valid = 1'b1; #1;
      tests++;
      if (req1_ready !== 1'b1) begin
         fails++; $display("FAIL rst_exec_ready: got %b expected 1", req1_ready);
      end
      @(posedge clk); @(negedge clk); req1_valid = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      tests++;
      if ({busy, resp_valid, alu_op} !== {1'b1, 1'b0, 4'd2}) begin
         fails++; $display("FAIL rst_exec_pre: busy=%b rv=%b op=%h expected 1 0 2", busy, resp_valid, alu_op);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      reset = 1'b1; #1;
      tests++;
      if ({busy, resp_valid, resp_out, resp_id, resp_err, alu_a, alu_b, alu_op, req0_ready, req1_ready} !== 56'd0) begin
         fails++; $display("FAIL rst_exec_async: busy=%b rv=%b out=%h id=%b err=%b a=%h b=%h op=%h r0=%b r1=%b expected all 0",
                           busy, resp_valid, resp_out, resp_id, resp_err, alu_a, alu_b, alu_op, req0_ready, req1_ready);
      end
      @(negedge clk); reset = 1'b0; #1;
      tests++;
      if ({req0_ready, req1_ready, busy} !== 3'b100) begin
         fails++; $display("FAIL rst_exec_tie: r0=%b r1=%b busy=%b expected 1 0 0", req0_ready, req1_ready, busy);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      test_reset;
      test_fast;
      test_slow_backpressure;
      test_tie;
      test_reset_mid_exec;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
